mult_ctrl: RTL

Multi-cycle controller for the 32x32 HI/LO multiply path of the pipelined core. It accepts MULT/MULTU issue from the execute stage and registers operand magnitudes. It sequences an unsigned `multu` datapath over a fixed multicycle window, applies sign correction, and owns the HI/LO registers. It raises a pipeline stall for any HI/LO access or new multiply issued while a product is pending, and supports MTHI/MTLO writes and flush-abort.

---
 rtl/mips_mul_pkg.sv | 16 +
 rtl/multu.sv | 12 +
 rtl/mult_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/mips_mul_pkg.sv
// Shared types and constants for the HI/LO multiply controller.
package mips_mul_pkg;

    typedef enum logic {IDLE, RUN} mul_state_t;

    localparam int HILO_W      = 32;
    localparam int MUL_LAT_MAX = 15;
    localparam int CNT_W       = $clog2(MUL_LAT_MAX + 1);

    // Magnitude for MULT; MULTU operands and non-negative MULT operands pass through.
    // |0x80000000| wraps back to 0x80000000, which is correct as an unsigned magnitude.
    function automatic logic [HILO_W-1:0] op_mag(input logic [HILO_W-1:0] x, input logic sgn);
        return (sgn && x[HILO_W-1]) ? (~x + HILO_W'(1)) : x;
    endfunction

endpackage

// File: rtl/multu.sv
// Unsigned 32x32->64 multiply datapath; timed as a multicycle path by the controller.
module multu
    import mips_mul_pkg::*;
(
    input  logic [HILO_W-1:0]   a_i,
    input  logic [HILO_W-1:0]   b_i,
    output logic [2*HILO_W-1:0] p_o
);

    assign p_o = {{HILO_W{1'b0}}, a_i} * {{HILO_W{1'b0}}, b_i};

endmodule

// File: rtl/mult_ctrl.sv
// Multi-cycle MULT/MULTU controller: operand capture, latency counter,
// sign correction, HI/LO ownership and pipeline stall generation.
module mult_ctrl
    import mips_mul_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_signed,
    input  logic [HILO_W-1:0] a,
    input  logic [HILO_W-1:0] b,
    input  logic              flush,
    input  logic              mthi_we,
    input  logic              mtlo_we,
    input  logic [HILO_W-1:0] wdata,
    input  logic              hilo_rd,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic [HILO_W-1:0] hi,
    output logic [HILO_W-1:0] lo
);

    mul_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [HILO_W-1:0]   a_q, a_d, b_q, b_d;
    logic                neg_q, neg_d;
    logic [HILO_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic                done_q, done_d;
    logic [2*HILO_W-1:0] prod;
    logic [2*HILO_W-1:0] prod_fix;

    multu u_multu (
        .a_i (a_q),
        .b_i (b_q),
        .p_o (prod)
    );

    assign prod_fix = neg_q ? (~prod + 64'd1) : prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // A flushed issue is dropped, and any MT write alongside it too.
                    if (!flush) begin
                        a_d     = op_mag(a, is_signed);
                        b_d     = op_mag(b, is_signed);
                        neg_d   = is_signed & (a[HILO_W-1] ^ b[HILO_W-1]);
                        cnt_d   = CNT_W'(LATENCY - 1);
                        state_d = RUN;
                    end
                end else begin
                    if (mthi_we) hi_d = wdata;
                    if (mtlo_we) lo_d = wdata;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    {hi_d, lo_d} = prod_fix;
                    done_d       = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q == RUN);
    assign stall = busy & (start | hilo_rd | mthi_we | mtlo_we);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
